// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one serial byte transmitter among N_REQ requesters.
// It grants one byte at a time, tracks the transmitter handshake, adds an optional gap, and aborts stuck bytes.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  output logic [$clog2(N_REQ)-1:0]    grant_id,
  output logic                        busy,
  output logic                        tx_start,
  output logic [DATA_WIDTH-1:0]       tx_din,
  input  logic                        tx_done,
  output logic                        timeout_err
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int WD_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ID_W-1:0]  PTR_RST  = ID_W'(N_REQ - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ACK_WAIT, XMIT, GAP} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   tx_din_q, tx_din_d;
  logic [ID_W-1:0]         grant_id_q, grant_id_d;
  logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [WD_W-1:0]         wd_cnt_q, wd_cnt_d;
  logic [GAP_W-1:0]        gap_cnt_q, gap_cnt_d;

  logic                    win_found;
  logic [ID_W-1:0]         win_idx;
  logic                    wd_expire;
  logic [DATA_WIDTH-1:0]   req_bytes [N_REQ];

  // First valid requester strictly after ptr, wrapping; MSB flags that one was found.
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                            input logic [ID_W-1:0]  ptr);
    logic [ID_W:0]   pick;
    logic [ID_W-1:0] idx;
    pick = '0;
    idx  = ptr;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (idx == PTR_RST) ? '0 : idx + ID_W'(1);
      if (!pick[ID_W] && valid[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] cnt);
    return (&cnt) ? cnt : cnt + WD_W'(1);
  endfunction

  for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign {win_found, win_idx} = rr_pick(req_valid, rr_ptr_q);
  assign wd_expire = (TIMEOUT_CYCLES != 0) && (wd_cnt_q == WD_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tx_din_q      <= '0;
      grant_id_q    <= '0;
      rr_ptr_q      <= PTR_RST;
      timeout_err_q <= 1'b0;
      wd_cnt_q      <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      tx_din_q      <= tx_din_d;
      grant_id_q    <= grant_id_d;
      rr_ptr_q      <= rr_ptr_d;
      timeout_err_q <= timeout_err_d;
      wd_cnt_q      <= wd_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tx_din_d      = tx_din_q;
    grant_id_d    = grant_id_q;
    rr_ptr_d      = rr_ptr_q;
    timeout_err_d = timeout_err_q;
    wd_cnt_d      = wd_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d    = ISSUE;
          tx_din_d   = req_bytes[win_idx];
          grant_id_d = win_idx;
          rr_ptr_d   = win_idx;
        end
      end
      ISSUE: begin
        state_d  = ACK_WAIT;
        wd_cnt_d = '0;
      end
      // A done still high here is left over from the previous byte.
      ACK_WAIT: begin
        wd_cnt_d = sat_inc(wd_cnt_q);
        if (wd_expire) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else if (!tx_done) begin
          state_d = XMIT;
        end
      end
      XMIT: begin
        wd_cnt_d = sat_inc(wd_cnt_q);
        if (tx_done) begin
          state_d   = (GAP_CYCLES > 0) ? GAP : IDLE;
          gap_cnt_d = '0;
        end else if (wd_expire) begin
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = IDLE;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // req_ready is gated by reset so no byte is consumed while reset is held.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !reset && win_found) req_ready[win_idx] = 1'b1;
    tx_start = (state_q == ISSUE);
    busy     = (state_q != IDLE);
  end

  assign tx_din      = tx_din_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares the single serial byte transmitter among N_REQ on-chip requesters, e.g. move reporter, board-state dumper and debug console. Each requester offers one byte at a time with a valid/ready handshake. The arbiter grants one requester, issues a one-cycle start pulse with the byte to the transmitter, and waits for the transmitter's completion flag. It then enforces an optional inter-byte gap. A watchdog aborts a transaction whose completion never arrives.

## Interface
- N_REQ, 4: number of requesters, 2..8
- DATA_WIDTH, 8: byte width, matches the transmitter
- GAP_CYCLES, 0: idle clk cycles inserted after each completed byte; 0 means no gap
- TIMEOUT_CYCLES, 65536: watchdog limit in clk cycles per transaction; 0 disables the watchdog

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- req_valid  in  N_REQ  per-requester byte available
- req_data  in  N_REQ*DATA_WIDTH  requester i byte at bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  N_REQ  one-hot accept pulse; the byte is consumed in the cycle where valid&ready
- grant_id  out  clog2(N_REQ)  index of the requester currently/last granted
- busy  out  1  high whenever state != IDLE
- tx_start  out  1  start pulse to the transmitter
- tx_din  out  DATA_WIDTH  byte to the transmitter
- tx_done  in  1  transmitter completion flag: cleared by the transmitter one cycle after it accepts tx_start, set when the stop bit ends, and stays set until the next start
- timeout_err  out  1  sticky watchdog error; cleared only by reset

## Operation
- States: IDLE, ISSUE, ACK_WAIT, XMIT, GAP.
- **IDLE**
  - If any req_valid is high, select the winner by round-robin: search from rr_ptr+1 upward, wrapping modulo N_REQ.
  - Assert req_ready[winner] combinationally in the same cycle.
  - Register tx_din <= winner's byte, grant_id <= winner and rr_ptr <= winner.
  - Go to ISSUE.
  - req_ready is all-zero in every other state.
- **ISSUE**: tx_start = 1 for exactly this one cycle. tx_din is stable and is held until the next grant. Go to ACK_WAIT.
- **ACK_WAIT**: wait for tx_done == 0. This confirms the transmitter accepted the start and discards a stale done left from the previous byte. Then go to XMIT.
- **XMIT**: wait for tx_done == 1. Then go to GAP if GAP_CYCLES > 0, else go to IDLE.
- **GAP**: count GAP_CYCLES cycles, then go to IDLE.
- **Watchdog**
  - A counter is cleared on entry to ACK_WAIT and increments in ACK_WAIT and XMIT.
  - On reaching TIMEOUT_CYCLES, set timeout_err and return to IDLE with no further action on the transmitter.
  - The counter width is clog2(TIMEOUT_CYCLES+1), saturating.
- **Fairness**: a requester that stays valid is not re-granted while another requester is valid. With all N_REQ valid, grants rotate strictly.
- **Data rule**: a requester must hold req_data stable while req_valid is high. The arbiter samples the byte only in the accept cycle.

## Timing
- Reset values:
  - state IDLE
  - tx_start 0
  - tx_din 0
  - req_ready 0
  - grant_id 0
  - busy 0
  - timeout_err 0
  - rr_ptr N_REQ-1, so requester 0 has first priority after reset
- Accept-to-start latency: tx_start is high on the cycle right after the req_ready pulse.
- busy rises on the cycle after accept and falls on the cycle the FSM re-enters IDLE.
- Back-to-back: with GAP_CYCLES=0, the next accept can occur on the first cycle back in IDLE, i.e. one cycle after tx_done is seen high in XMIT.
- Simultaneous events:
  - A req_valid that drops in the same cycle as the IDLE decision is not granted, because the decision uses the current req_valid.
  - A req_valid rising during a transaction waits for the next IDLE.
- tx_done already high in ACK_WAIT (stale): the FSM stays in ACK_WAIT until it falls.
- tx_done never low: the watchdog fires after TIMEOUT_CYCLES.
- Reset mid-transaction: all state and outputs return to reset values immediately, asynchronously. The transmitter is reset by the same signal.

## Test plan
1. **Single requester**: req_valid=4'b0100, data 8'hA5 → req_ready=4'b0100 for 1 cycle, grant_id=2, tx_start 1 cycle later with tx_din=8'hA5; busy is low on the cycle after tx_done rises.
2. **All four valid continuously** after reset → grant order 0,1,2,3,0 with exactly one tx_start per byte; a transmitter model shows no overlapping frames.
3. **Fairness**: requesters 0 and 2 held valid → grants alternate 0,2,0,2; requester 0 is never granted twice in a row.
4. **Stale done**: tx_done held 1 from the previous byte, model clears it 1 cycle after tx_start → the FSM does not leave XMIT until tx_done re-rises; exactly one byte per grant.
5. **Watchdog**: TIMEOUT_CYCLES=100, tx_done stuck 0 → timeout_err=1 exactly 100 cycles after ACK_WAIT entry, FSM in IDLE, next request still served; timeout_err stays 1.
6. **Reset during XMIT, then GAP_CYCLES=3 run**:
   - Reset during XMIT → all outputs are at reset values in the same cycle, and the first post-reset grant goes to requester 0.
   - With GAP_CYCLES=3 → exactly 3 idle cycles between tx_done rising and the next req_ready.
